// File: rtl/game_flow_ctrl.sv
// Breakout game-flow sequencer: start screen, timed level load, play, pause,
// game-over and win screens, with lives and level tracking.
module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int GAME_RST_CYC = 16,
    parameter int END_HOLD_CYC = 25_000_000,
    parameter int PAUSE_EN     = 1,
    localparam int LW  = $clog2(LIVES + 1),
    localparam int VW  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int LCW = (GAME_RST_CYC > 1) ? $clog2(GAME_RST_CYC) : 1,
    localparam int HW  = (END_HOLD_CYC > 0) ? $clog2(END_HOLD_CYC + 1) : 1
) (
    input  logic          vga_clk,
    input  logic          sys_rst,
    input  logic          ok_flag,
    input  logic          back_flag,
    input  logic          game_over,
    input  logic          level_clear,
    output logic [2:0]    state,
    output logic [1:0]    pic_sel,
    output logic          game_rst_n,
    output logic          game_run,
    output logic [LW-1:0] lives,
    output logic [VW-1:0] level
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_END   = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    // Plain vector so unused codes 6/7 stay representable and recoverable.
    logic [2:0]     state_q, state_d;
    logic [LW-1:0]  lives_q, lives_d;
    logic [VW-1:0]  level_q, level_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (sys_rst) begin
            state_q    <= ST_START;
            lives_q    <= '0;
            level_q    <= '0;
            load_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            load_cnt_q <= load_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch;
        // counters default to 0, which also clears them on entry to LOAD/END/WIN.
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        load_cnt_d = '0;
        hold_cnt_d = '0;
        case (state_q)
            ST_START: begin
                if (ok_flag && !back_flag) begin
                    state_d = ST_LOAD;
                    lives_d = LW'(LIVES);
                    level_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LCW'(GAME_RST_CYC - 1)) state_d    = ST_PLAY;
                else                                      load_cnt_d = load_cnt_q + 1'b1;
            end
            ST_PLAY: begin
                // Events outrank key flags; ball loss outranks level clear.
                if (game_over) begin
                    if (lives_q == LW'(1)) begin
                        lives_d = '0;
                        state_d = ST_END;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        state_d = ST_LOAD;
                    end
                end else if (level_clear) begin
                    if (level_q == VW'(NUM_LEVELS - 1)) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d = level_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end else if (back_flag) begin
                    state_d = ST_START;
                end else if (ok_flag && (PAUSE_EN != 0)) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (back_flag)    state_d = ST_START;
                else if (ok_flag) state_d = ST_PLAY;
            end
            ST_END, ST_WIN: begin
                if (hold_cnt_q != HW'(END_HOLD_CYC)) hold_cnt_d = hold_cnt_q + 1'b1;
                else                                 hold_cnt_d = hold_cnt_q;
                if (back_flag) begin
                    state_d = ST_START;
                end else if (ok_flag && (hold_cnt_q == HW'(END_HOLD_CYC))) begin
                    state_d = ST_LOAD;
                    lives_d = LW'(LIVES);
                    level_d = '0;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_comb begin
        pic_sel    = 2'd0;
        game_rst_n = 1'b0;
        game_run   = 1'b0;
        case (state_q)
            ST_LOAD:  pic_sel = 2'd1;
            ST_PLAY: begin
                pic_sel    = 2'd1;
                game_rst_n = 1'b1;
                game_run   = 1'b1;
            end
            ST_PAUSE: begin
                pic_sel    = 2'd1;
                game_rst_n = 1'b1;
            end
            ST_END: begin
                pic_sel    = 2'd2;
                game_rst_n = 1'b1;
            end
            ST_WIN: begin
                pic_sel    = 2'd3;
                game_rst_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;
    assign lives = lives_q;
    assign level = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: LIVES=3, NUM_LEVELS=2, GAME_RST_CYC=4,
// END_HOLD_CYC=8, PAUSE_EN=1.
module tb_game_flow_ctrl;

    logic       vga_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       ok_flag = 1'b0;
    logic       back_flag = 1'b0;
    logic       game_over = 1'b0;
    logic       level_clear = 1'b0;
    logic [2:0] state;
    logic [1:0] pic_sel;
    logic       game_rst_n;
    logic       game_run;
    logic [1:0] lives;
    logic [0:0] level;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_v;
    int n;

    game_flow_ctrl #(
        .LIVES(3), .NUM_LEVELS(2), .GAME_RST_CYC(4), .END_HOLD_CYC(8), .PAUSE_EN(1)
    ) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .ok_flag(ok_flag), .back_flag(back_flag),
        .game_over(game_over), .level_clear(level_clear), .state(state), .pic_sel(pic_sel),
        .game_rst_n(game_rst_n), .game_run(game_run), .lives(lives), .level(level)
    );

    always #5 vga_clk = ~vga_clk;

    // Observed bundle: {state, pic_sel, game_rst_n, game_run, lives, level}.
    wire [9:0] obs = {state, pic_sel, game_rst_n, game_run, lives, level};

    function automatic logic [9:0] e(input logic [2:0] st, input logic [1:0] pic,
                                     input logic rn, input logic run,
                                     input logic [1:0] lv, input logic lev);
        return {st, pic, rn, run, lv, lev};
    endfunction

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse(input logic ok, input logic bk, input logic go, input logic lc);
        ok_flag = ok; back_flag = bk; game_over = go; level_clear = lc;
        tick();
        ok_flag = 0; back_flag = 0; game_over = 0; level_clear = 0;
    endtask

    // Counts consecutive LOAD cycles with game_rst_n low, starting at the current one.
    task automatic run_load(output int cnt);
        cnt = 0;
        while (state == 3'd1 && game_rst_n == 1'b0 && cnt < 50) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        sys_rst = 1;
        tick();
        sys_rst = 0;
    endtask

    task automatic test_reset_and_start();
        do_reset();
        exp_v = e(3'd0, 2'd0, 0, 0, 2'd0, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        pulse(1, 0, 0, 0);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL start_to_load: got %h want %h", obs, exp_v); end
        run_load(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL load_len_start: got %0d want 4", n); end
        exp_v = e(3'd2, 2'd1, 1, 1, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL first_play: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_lives();
        pulse(0, 0, 1, 0);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd2, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL lose_1: got %h want %h", obs, exp_v); end
        run_load(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL load_len_lose1: got %0d want 4", n); end
        pulse(0, 0, 1, 0);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd1, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL lose_2: got %h want %h", obs, exp_v); end
        run_load(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL load_len_lose2: got %0d want 4", n); end
        pulse(0, 0, 1, 0);
        exp_v = e(3'd4, 2'd2, 1, 0, 2'd0, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL lose_3_end: got %h want %h", obs, exp_v); end
        // Now at hold count 0; early presses at 3 and 7 must be dropped.
        repeat (3) tick();
        pulse(1, 0, 0, 0);
        tests++; if (state !== 3'd4) begin fails++; $display("FAIL end_ok_hold3: got %0d want 4", state); end
        repeat (3) tick();
        pulse(1, 0, 0, 0);
        tests++; if (state !== 3'd4) begin fails++; $display("FAIL end_ok_hold7: got %0d want 4", state); end
        pulse(1, 0, 0, 0);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL end_ok_hold8: got %h want %h", obs, exp_v); end
        run_load(n);
    endtask

    task automatic test_levels();
        pulse(0, 0, 0, 1);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd3, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL level_up: got %h want %h", obs, exp_v); end
        run_load(n);
        exp_v = e(3'd2, 2'd1, 1, 1, 2'd3, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL play_level1: got %h want %h", obs, exp_v); end
        pulse(0, 0, 0, 1);
        exp_v = e(3'd5, 2'd3, 1, 0, 2'd3, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL win: got %h want %h", obs, exp_v); end
        pulse(0, 1, 0, 0);
        exp_v = e(3'd0, 2'd0, 0, 0, 2'd3, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL win_back: got %h want %h", obs, exp_v); end
        pulse(1, 0, 0, 0);
        run_load(n);
    endtask

    task automatic test_pause();
        pulse(1, 0, 0, 0);
        exp_v = e(3'd3, 2'd1, 1, 0, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL pause: got %h want %h", obs, exp_v); end
        pulse(0, 0, 1, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL pause_ignore_go: got %h want %h", obs, exp_v); end
        pulse(1, 0, 0, 0);
        exp_v = e(3'd2, 2'd1, 1, 1, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL resume: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_simultaneous();
        // Event beats key flag: level_clear + ok advances the level.
        pulse(1, 0, 0, 1);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd3, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL lc_plus_ok: got %h want %h", obs, exp_v); end
        run_load(n);
        pulse(0, 0, 1, 0);
        run_load(n);
        pulse(0, 0, 1, 1);
        exp_v = e(3'd1, 2'd1, 0, 0, 2'd1, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL go_plus_lc: got %h want %h", obs, exp_v); end
        run_load(n);
        pulse(0, 1, 1, 0);
        exp_v = e(3'd4, 2'd2, 1, 0, 2'd0, 1);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL go_plus_back: got %h want %h", obs, exp_v); end
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        run_load(n);
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        exp_v = e(3'd0, 2'd0, 0, 0, 2'd3, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL ok_plus_back_pause: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_sys_rst();
        pulse(1, 0, 0, 0);
        repeat (2) tick();
        do_reset();
        exp_v = e(3'd0, 2'd0, 0, 0, 2'd0, 0);
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL rst_mid_load: got %h want %h", obs, exp_v); end
        pulse(1, 0, 0, 0);
        run_load(n);
        tests++; if (n !== 4) begin fails++; $display("FAIL load_len_after_rst: got %0d want 4", n); end
        pulse(1, 0, 0, 0);
        do_reset();
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL rst_mid_pause: got %h want %h", obs, exp_v); end
        sys_rst = 1; ok_flag = 1;
        tick();
        sys_rst = 0; ok_flag = 0;
        tests++; if (obs !== exp_v) begin fails++; $display("FAIL rst_over_ok: got %h want %h", obs, exp_v); end
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        tests++; if (state !== 3'd7) begin fails++; $display("FAIL illegal_forced: got %0d want 7", state); end
        tick();
        tests++; if (state !== 3'd0) begin fails++; $display("FAIL illegal_recover: got %0d want 0", state); end
    endtask

    initial begin
        #1;
        test_reset_and_start();
        test_lives();
        test_levels();
        test_pause();
        test_simultaneous();
        test_sys_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
